// File: rtl/osd_arb_pkg.sv
// osd_arb_pkg: shared state type and sizing constants for the OSD command arbiter.
package osd_arb_pkg;

   localparam int unsigned N_REQ  = 2;
   localparam int unsigned WORD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_STB_HI = 3'd3,
      ST_STB_LO = 3'd4,
      ST_GAP    = 3'd5
   } arb_state_e;

endpackage

// File: rtl/osd_arb_rr.sv
// osd_arb_rr: two-way round-robin pick; the requester not picked last wins a tie.
module osd_arb_rr
   import osd_arb_pkg::*;
(
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] valid,
   input  logic             update,
   output logic [N_REQ-1:0] grant
);

   // last_r resets to 1 so that requester 0 takes the first tie
   logic             last_r;
   logic [N_REQ-1:0] grant_s;

   // one-hot pick from the valid vector and the pointer
   always_comb begin
      grant_s = 2'b00;
      case (valid)
         2'b01:   grant_s = 2'b01;
         2'b10:   grant_s = 2'b10;
         2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
         default: grant_s = 2'b00;
      endcase
   end

   // pointer records the requester taken on each pick
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         last_r <= 1'b1;
      end else if (update) begin
         last_r <= grant_s[1];
      end else begin
         last_r <= last_r;
      end
   end

   assign grant = grant_s;

endmodule

// File: rtl/osd_cmd_arb.sv
// osd_cmd_arb: arbitrates two word-burst requesters onto the strobed OSD command bus.
// Optional LOAD stall timeout with abort pulse is enabled by defining OSD_ARB_TIMEOUT_EN.
module osd_cmd_arb
   import osd_arb_pkg::*;
#(
   parameter int unsigned STB_CYCLES = 2,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                    clk_sys,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        rq_valid,
   input  logic [N_REQ*WORD_W-1:0] rq_data,
   input  logic [N_REQ-1:0]        rq_last,
   output logic [N_REQ-1:0]        rq_ready,
   output logic                    io_osd,
   output logic                    io_strobe,
   output logic [WORD_W-1:0]       io_din,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic                    abort
);

   localparam int unsigned STB_W = 4;
   localparam int unsigned GAP_W = 8;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STB_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

   arb_state_e        state_r;
   arb_state_e        state_s;
   logic [STB_W-1:0]  stb_cnt_r;
   logic [GAP_W-1:0]  gap_cnt_r;
   logic [TMO_W-1:0]  tmo_cnt_r;
   logic [N_REQ-1:0]  grant_r;
   logic [N_REQ-1:0]  rr_grant_s;
   logic [WORD_W-1:0] din_r;
   logic [WORD_W-1:0] gdata_s;
   logic              last_r;
   logic              osd_r;
   logic              strobe_r;
   logic              busy_r;
   logic              abort_r;
   logic              gvalid_s;
   logic              glast_s;
   logic              pick_s;
   logic              accept_s;
   logic              tmo_pre_s;
   logic              tmo_hit_s;

   assign gvalid_s = |(rq_valid & grant_r);
   assign glast_s  = |(rq_last & grant_r);
   assign gdata_s  = grant_r[1] ? rq_data[2*WORD_W-1:WORD_W] : rq_data[WORD_W-1:0];
   assign pick_s   = (state_r == ST_IDLE) && (|rq_valid);
   assign accept_s = (state_r == ST_LOAD) && gvalid_s && !tmo_hit_s;

`ifdef OSD_ARB_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_PRE = TMO_W'(TIMEOUT - 1);
   // abort is registered one cycle ahead of the forced exit so it leads io_osd falling
   assign tmo_pre_s = (state_r == ST_LOAD) && !gvalid_s && (tmo_cnt_r == TMO_PRE);
   assign tmo_hit_s = (state_r == ST_LOAD) && (tmo_cnt_r == TMO_MAX);
`else
   assign tmo_pre_s = 1'b0;
   assign tmo_hit_s = 1'b0;
`endif

   osd_arb_rr u_rr (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .valid   (rq_valid),
      .update  (pick_s),
      .grant   (rr_grant_s)
   );

   // next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_s) state_s = ST_SETUP;
            else        state_s = ST_IDLE;
         end
         ST_SETUP: state_s = ST_LOAD;
         ST_LOAD: begin
            if (tmo_hit_s)     state_s = ST_GAP;
            else if (gvalid_s) state_s = ST_STB_HI;
            else               state_s = ST_LOAD;
         end
         ST_STB_HI: begin
            if (stb_cnt_r == STB_LAST) state_s = ST_STB_LO;
            else                       state_s = ST_STB_HI;
         end
         ST_STB_LO: begin
            if (stb_cnt_r != STB_LAST) state_s = ST_STB_LO;
            else if (last_r)           state_s = ST_GAP;
            else                       state_s = ST_LOAD;
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_LAST) state_s = ST_IDLE;
            else                       state_s = ST_GAP;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // state, registered bus outputs and captured word
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= ST_IDLE;
         osd_r    <= 1'b0;
         strobe_r <= 1'b0;
         busy_r   <= 1'b0;
         abort_r  <= 1'b0;
         grant_r  <= 2'b00;
         din_r    <= 16'h0000;
         last_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         osd_r    <= (state_s == ST_SETUP) || (state_s == ST_LOAD) ||
                     (state_s == ST_STB_HI) || (state_s == ST_STB_LO);
         strobe_r <= (state_s == ST_STB_HI);
         busy_r   <= (state_s != ST_IDLE);
         abort_r  <= tmo_pre_s;
         if (pick_s)                grant_r <= rr_grant_s;
         else if (state_s == ST_GAP) grant_r <= 2'b00;
         else                       grant_r <= grant_r;
         if (accept_s) begin
            din_r  <= gdata_s;
            last_r <= glast_s;
         end else begin
            din_r  <= din_r;
            last_r <= last_r;
         end
      end
   end

   // strobe, gap and stall counters; the stall counter restarts on every LOAD entry
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         stb_cnt_r <= 4'd0;
         gap_cnt_r <= 8'd0;
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
         if (((state_r == ST_STB_HI) || (state_r == ST_STB_LO)) && (stb_cnt_r != STB_LAST))
            stb_cnt_r <= stb_cnt_r + 4'd1;
         else
            stb_cnt_r <= 4'd0;
         if ((state_r == ST_GAP) && (gap_cnt_r != GAP_LAST))
            gap_cnt_r <= gap_cnt_r + 8'd1;
         else
            gap_cnt_r <= 8'd0;
         if (state_r != ST_LOAD)
            tmo_cnt_r <= {TMO_W{1'b0}};
         else if (!gvalid_s && (tmo_cnt_r != TMO_MAX))
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
         else
            tmo_cnt_r <= tmo_cnt_r;
      end
   end

   assign rq_ready  = accept_s ? grant_r : 2'b00;
   assign io_osd    = osd_r;
   assign io_strobe = strobe_r;
   assign io_din    = din_r;
   assign grant     = grant_r;
   assign busy      = busy_r;
   assign abort     = abort_r;

endmodule

// File: tb/tb_osd_cmd_arb.sv
// tb_osd_cmd_arb: scoreboard bench; expected {grant, word} pairs are queued at stimulus time
// and popped on each io_strobe rising edge.
module tb_osd_cmd_arb;

   localparam int STB = 2;
   localparam int GAP = 4;
   localparam int TMO = 16;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [1:0]  rq_valid;
   logic [31:0] rq_data;
   logic [1:0]  rq_last;
   logic [1:0]  rq_ready;
   logic        io_osd;
   logic        io_strobe;
   logic [15:0] io_din;
   logic [1:0]  grant;
   logic        busy;
   logic        abort;

   logic [16:0] q0[$];
   logic [16:0] q1[$];
   logic [17:0] exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobe_rises = 0;
   int rise_cyc = 0;
   int abort_cyc = 0;
   int osd_fall_cyc = 0;
   int osd_len = 0;
   int last_osd_len = 0;
   int gap_len = 0;
   int abort_n = 0;
   int rdy_bad = 0;
   int rdy_seen = 0;
   int acc_exp = 0;

   always #5 clk_sys = ~clk_sys;

   osd_cmd_arb #(
      .STB_CYCLES (STB),
      .GAP_CYCLES (GAP),
      .TIMEOUT    (TMO)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .rq_valid  (rq_valid),
      .rq_data   (rq_data),
      .rq_last   (rq_last),
      .rq_ready  (rq_ready),
      .io_osd    (io_osd),
      .io_strobe (io_strobe),
      .io_din    (io_din),
      .grant     (grant),
      .busy      (busy),
      .abort     (abort)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_word(input int r, input logic last, input logic [15:0] d);
      if (r == 0) q0.push_back({last, d});
      else        q1.push_back({last, d});
      acc_exp++;
   endtask

   task automatic expect_word(input logic [1:0] g, input logic [15:0] d);
      exp_q.push_back({g, d});
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      do begin
         @(posedge clk_sys); #1;
         n++;
      end while ((n < bound) &&
                 !((exp_q.size() == 0) && (q0.size() == 0) && (q1.size() == 0) && !busy));
      chk("done_busy", busy, 0);
      chk("sb_left", exp_q.size(), 0);
   endtask

   // requester drivers: present queue heads, garbage data whenever valid is low
   initial begin
      logic [1:0]  acc;
      logic [31:0] rnd;
      rq_valid = 2'b00;
      rq_data  = 32'h0000_0000;
      rq_last  = 2'b00;
      acc      = 2'b00;
      forever begin
         @(posedge clk_sys); #1;
         if (acc[0] && (q0.size() != 0)) void'(q0.pop_front());
         if (acc[1] && (q1.size() != 0)) void'(q1.pop_front());
         rnd = $urandom;
         if (q0.size() != 0) begin
            rq_valid[0] = 1'b1; rq_data[15:0] = q0[0][15:0]; rq_last[0] = q0[0][16];
         end else begin
            rq_valid[0] = 1'b0; rq_data[15:0] = rnd[15:0]; rq_last[0] = rnd[16];
         end
         if (q1.size() != 0) begin
            rq_valid[1] = 1'b1; rq_data[31:16] = q1[0][15:0]; rq_last[1] = q1[0][16];
         end else begin
            rq_valid[1] = 1'b0; rq_data[31:16] = rnd[31:16]; rq_last[1] = rnd[17];
         end
         @(negedge clk_sys);
         acc = rq_ready;
      end
   end

   // handshake monitor
   initial begin
      forever begin
         @(negedge clk_sys);
         if (reset_n) begin
            if (((rq_ready & ~grant) != 2'b00) || ((rq_ready & ~rq_valid) != 2'b00)) rdy_bad++;
            if (rq_ready != 2'b00) rdy_seen++;
         end
      end
   end

   // bus monitor: scoreboard pops, burst length, gap length, abort timing
   initial begin
      logic        p_strobe, p_osd, p_busy, p_abort;
      logic [17:0] e;
      p_strobe = 1'b0; p_osd = 1'b0; p_busy = 1'b0; p_abort = 1'b0;
      forever begin
         @(posedge clk_sys); #1;
         cyc++;
         if (!reset_n) begin
            p_strobe = 1'b0; p_osd = 1'b0; p_busy = 1'b0; p_abort = 1'b0;
            osd_len = 0; gap_len = 0;
         end else begin
            if (io_strobe && !p_strobe) begin
               strobe_rises++;
               rise_cyc = cyc;
               if (exp_q.size() == 0) begin
                  chk("sb_extra", 0, 1);
               end else begin
                  e = exp_q.pop_front();
                  chk("din", io_din, e[15:0]);
                  chk("grant", grant, e[17:16]);
               end
            end
            if (io_osd && !p_osd) osd_len = 0;
            if (io_osd) osd_len++;
            if (!io_osd && p_osd) begin
               last_osd_len = osd_len;
               osd_fall_cyc = cyc;
               gap_len = 0;
            end
            if (busy && !io_osd) gap_len++;
            if (!busy && p_busy) chk("gap_len", gap_len, GAP);
            if (abort) begin
               if (!p_abort) abort_cyc = cyc;
               abort_n++;
            end
            p_strobe = io_strobe; p_osd = io_osd; p_busy = busy; p_abort = abort;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      reset_n = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_osd", io_osd, 0);
      chk("rst_strobe", io_strobe, 0);
      chk("rst_din", io_din, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_abort", abort, 0);
      chk("rst_ready", rq_ready, 0);
      @(negedge clk_sys);
      reset_n = 1'b1;

      // three-word burst from requester 0
      push_word(0, 1'b0, 16'h0021); expect_word(2'b01, 16'h0021);
      push_word(0, 1'b0, 16'h00AA); expect_word(2'b01, 16'h00AA);
      push_word(0, 1'b1, 16'h0055); expect_word(2'b01, 16'h0055);
      wait_done(300);
      chk("osd_len", last_osd_len, 1 + 3 * (1 + 2 * STB));

      // reset during STB_HI of the second word
      base = strobe_rises;
      push_word(0, 1'b0, 16'h0101); expect_word(2'b01, 16'h0101);
      push_word(0, 1'b0, 16'h0202); expect_word(2'b01, 16'h0202);
      push_word(0, 1'b1, 16'h0303);
      n = 0;
      while ((strobe_rises < base + 2) && (n < 300)) begin
         @(posedge clk_sys); #1;
         n++;
      end
      chk("rst_reach", strobe_rises - base, 2);
      #2;
      reset_n = 1'b0;
      acc_exp = acc_exp - q0.size() - q1.size();
      q0.delete();
      q1.delete();
      #1;
      chk("mid_osd", io_osd, 0);
      chk("mid_strobe", io_strobe, 0);
      chk("mid_grant", grant, 0);
      chk("mid_busy", busy, 0);
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1'b1;
      chk("sb_rst", exp_q.size(), 0);

      // both valid right after reset: requester 0 first
      push_word(0, 1'b1, 16'h0040);
      push_word(1, 1'b1, 16'h0040);
      expect_word(2'b01, 16'h0040);
      expect_word(2'b10, 16'h0040);
      wait_done(300);

      // alternation with both requesters continuously valid
      for (int i = 0; i < 3; i++) begin
         push_word(0, 1'b1, 16'h0A00 + 16'(i));
         push_word(1, 1'b1, 16'h0B00 + 16'(i));
         expect_word(2'b01, 16'h0A00 + 16'(i));
         expect_word(2'b10, 16'h0B00 + 16'(i));
      end
      wait_done(600);

`ifdef OSD_ARB_TIMEOUT_EN
      // stall after one non-last word: abort then gap
      abort_n = 0;
      push_word(0, 1'b0, 16'h0077); expect_word(2'b01, 16'h0077);
      wait_done(300);
      chk("abort_dly", abort_cyc - rise_cyc, 2 * STB + TMO);
      chk("abort_osd", osd_fall_cyc - abort_cyc, 1);
      chk("abort_width", abort_n, 1);
`else
      // stall after one non-last word: LOAD waits indefinitely
      push_word(0, 1'b0, 16'h0077); expect_word(2'b01, 16'h0077);
      repeat (4 * TMO) @(posedge clk_sys);
      #1;
      chk("stall_busy", busy, 1);
      chk("stall_osd", io_osd, 1);
      chk("stall_strobe", io_strobe, 0);
      chk("stall_abort", abort_n, 0);
      push_word(0, 1'b1, 16'h0078); expect_word(2'b01, 16'h0078);
      wait_done(300);
`endif

      chk("ready_rule", rdy_bad, 0);
      chk("ready_count", rdy_seen, acc_exp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
